// File: rtl/sv_uart_pkg.sv
// Shared UART definitions used by the receiver and the transmitter.
package sv_uart_pkg;
  localparam int UART_DATA_WIDTH = 8;
  localparam int UART_STOP_BITS  = 1;
  localparam int UART_DIV_MIN    = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_e;

  // Dividers below the minimum cannot place a half-period sample point.
  function automatic logic div_ok(input logic [15:0] div);
    return div >= 16'(UART_DIV_MIN);
  endfunction
endpackage

// File: rtl/sv_uart_baud.sv
// Bit-period counter with half- and full-period strobes; shared by rx and tx.
module sv_uart_baud (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [15:0] div_i,
  output logic        half_o,
  output logic        full_o
);
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] half_thr, full_thr;

  assign half_thr = {1'b0, div_i[15:1]} - 16'd1;
  assign full_thr = div_i - 16'd1;

  // >= rather than == so a divider lowered mid-frame hits at the next compare
  assign half_o = en_i && (cnt_q >= half_thr);
  assign full_o = en_i && (cnt_q >= full_thr);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/sv_uart_rx.sv
// UART receiver: mid-bit sampling, stop-bit check, AXI-stream output with overrun drop.
module sv_uart_rx
  import sv_uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int STOP_BITS  = UART_STOP_BITS
) (
  input  logic                  iclk,
  input  logic                  irst,
  input  logic                  irx,
  input  logic [15:0]           idivider,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  oframe_err,
  output logic                  ooverrun
);
  localparam int BCW = $clog2(DATA_WIDTH + STOP_BITS + 1);

  uart_state_e           state_q, state_d;
  logic [1:0]            sync_q;
  logic                  prev_q;
  logic                  rx_s;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  stop_ok_q, stop_ok_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  ferr_q, ferr_d;
  logic                  ovr_q, ovr_d;
  logic                  baud_clr, baud_en, half_hit, full_hit;
  logic                  deliver, frame_bad, last_ok;

  assign rx_s = sync_q[1];

  sv_uart_baud u_baud (
    .clk_i  (iclk),
    .rst_i  (irst),
    .clr_i  (baud_clr),
    .en_i   (baud_en),
    .div_i  (idivider),
    .half_o (half_hit),
    .full_o (full_hit)
  );

  assign last_ok = stop_ok_q & rx_s;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    stop_ok_d = stop_ok_q;
    baud_clr  = 1'b0;
    baud_en   = (state_q != ST_IDLE);
    deliver   = 1'b0;
    frame_bad = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // prev_q only rises once the line is high, so a break cannot re-trigger
        if (prev_q && !rx_s) begin
          state_d  = ST_START;
          baud_clr = 1'b1;
        end
      end
      ST_START: begin
        if (half_hit) begin
          baud_clr  = 1'b1;
          bit_cnt_d = '0;
          state_d   = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (full_hit) begin
          baud_clr = 1'b1;
          shift_d  = DATA_WIDTH'({rx_s, shift_q} >> 1);
          if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) begin
            state_d   = ST_STOP;
            bit_cnt_d = '0;
            stop_ok_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      end
      ST_STOP: begin
        if (full_hit) begin
          baud_clr  = 1'b1;
          stop_ok_d = last_ok;
          if (bit_cnt_q == BCW'(STOP_BITS - 1)) begin
            state_d   = ST_IDLE;
            deliver   = last_ok;
            frame_bad = !last_ok;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!div_ok(idivider)) begin
      state_d   = ST_IDLE;
      baud_en   = 1'b0;
      deliver   = 1'b0;
      frame_bad = 1'b0;
    end
  end

  always_comb begin
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    ferr_d   = frame_bad;
    ovr_d    = 1'b0;
    if (tvalid_q && m_axis_tready) tvalid_d = 1'b0;
    if (deliver) begin
      if (!tvalid_q || m_axis_tready) begin
        tdata_d  = shift_q;
        tvalid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q   <= ST_IDLE;
      sync_q    <= 2'b11;
      prev_q    <= 1'b1;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      stop_ok_q <= 1'b0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[0], irx};
      prev_q    <= rx_s;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      stop_ok_q <= stop_ok_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign oframe_err    = ferr_q;
  assign ooverrun      = ovr_q;
endmodule

// File: tb/tb_sv_uart_rx.sv
// Scoreboard bench for sv_uart_rx: directed frames, monitor pops expected words on handshake.
module tb_sv_uart_rx;
  logic        iclk = 1'b0;
  logic        irst, irx, m_axis_tready;
  logic [15:0] idivider;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid, oframe_err, ooverrun;

  int errors = 0;
  int checks = 0;
  int err_seen = 0;
  int ovr_seen = 0;
  int div_cur = 16;
  bit rnd_on = 1'b0;
  logic [7:0] exp_q[$];

  logic       pv = 1'b0, pr = 1'b0;
  logic [7:0] pd = '0;

  sv_uart_rx dut (
    .iclk          (iclk),
    .irst          (irst),
    .irx           (irx),
    .idivider      (idivider),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .oframe_err    (oframe_err),
    .ooverrun      (ooverrun)
  );

  always #5 iclk = ~iclk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops on handshake, counts pulses, checks hold-stability.
  always @(negedge iclk) begin
    if (!irst) begin
      if (pv && !pr) begin
        checks++;
        if (!m_axis_tvalid || m_axis_tdata != pd) begin
          errors++;
          $display("FAIL hold: tvalid=%0b tdata=0x%0h expected tvalid=1 tdata=0x%0h",
                   m_axis_tvalid, m_axis_tdata, pd);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got 0x%0h expected none", m_axis_tdata);
        end else begin
          chk("tdata", int'(m_axis_tdata), int'(exp_q.pop_front()));
        end
      end
      if (oframe_err) err_seen++;
      if (ooverrun)   ovr_seen++;
    end
    pv = m_axis_tvalid && !irst;
    pr = m_axis_tready;
    pd = m_axis_tdata;
  end

  task automatic idle(input int n);
    irx = 1'b1;
    repeat (n) @(negedge iclk);
  endtask

  task automatic drive_bit(input logic v);
    irx = v;
    repeat (div_cur) @(negedge iclk);
  endtask

  task automatic send(input logic [7:0] d, input logic stop_v);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_v);
  endtask

  task automatic wait_drain(input string name, input int maxc);
    for (int i = 0; i < maxc && exp_q.size() != 0; i++) @(negedge iclk);
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, o0;
    irst = 1'b1; irx = 1'b1; m_axis_tready = 1'b1; idivider = 16'd16;
    repeat (3) @(negedge iclk);
    chk("rst_tvalid", int'(m_axis_tvalid), 0);
    chk("rst_tdata",  int'(m_axis_tdata),  0);
    chk("rst_ferr",   int'(oframe_err),    0);
    chk("rst_ovr",    int'(ooverrun),      0);
    irst = 1'b0;
    idle(10);

    // Clean 8N1 frame
    e0 = err_seen;
    exp_q.push_back(8'hA5);
    send(8'hA5, 1'b1);
    idle(32);
    wait_drain("a5_drain", 200);
    chk("a5_ferr", err_seen - e0, 0);

    // Short low glitch is a false start
    e0 = err_seen;
    irx = 1'b0;
    repeat (3) @(negedge iclk);
    idle(40);
    chk("glitch_tvalid", int'(m_axis_tvalid), 0);
    chk("glitch_ferr", err_seen - e0, 0);

    // Bad stop bit
    e0 = err_seen;
    send(8'h3C, 1'b0);
    idle(40);
    chk("3c_ferr", err_seen - e0, 1);
    chk("3c_tvalid", int'(m_axis_tvalid), 0);

    // Overrun while downstream stalls
    o0 = ovr_seen;
    m_axis_tready = 1'b0;
    exp_q.push_back(8'h11);
    send(8'h11, 1'b1);
    idle(20);
    send(8'h22, 1'b1);
    idle(40);
    chk("ovr_tvalid", int'(m_axis_tvalid), 1);
    chk("ovr_tdata", int'(m_axis_tdata), 8'h11);
    chk("ovr_count", ovr_seen - o0, 1);
    m_axis_tready = 1'b1;
    wait_drain("ovr_drain", 50);
    @(negedge iclk);
    chk("ovr_tvalid_fall", int'(m_axis_tvalid), 0);

    // Reset during the data bits of 0x5A, then a clean 0xC3
    e0 = err_seen;
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    irst = 1'b1; irx = 1'b1;
    repeat (2) @(negedge iclk);
    irst = 1'b0;
    idle(40);
    chk("rst_mid_tvalid", int'(m_axis_tvalid), 0);
    exp_q.push_back(8'hC3);
    send(8'hC3, 1'b1);
    idle(32);
    wait_drain("c3_drain", 200);
    chk("c3_ferr", err_seen - e0, 0);

    // Back-to-back frames at divider 10 with random ready
    e0 = err_seen; o0 = ovr_seen;
    div_cur = 10; idivider = 16'd10;
    idle(20);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h55);
    rnd_on = 1'b1;
    fork
      begin
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        send(8'h55, 1'b1);
        idle(30);
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(negedge iclk);
          m_axis_tready = 1'($urandom_range(0, 1));
        end
      end
    join
    m_axis_tready = 1'b1;
    wait_drain("b2b_drain", 50);
    chk("b2b_ferr", err_seen - e0, 0);
    chk("b2b_ovr", ovr_seen - o0, 0);

    // Divider below minimum: receiver stays idle
    e0 = err_seen;
    div_cur = 2; idivider = 16'd2;
    idle(10);
    send(8'h00, 1'b0);
    idle(40);
    chk("div2_tvalid", int'(m_axis_tvalid), 0);
    chk("div2_ferr", err_seen - e0, 0);
    chk("final_queue", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
